// File: rtl/n_input_gate_sweep_checker.sv
// Exhaustive sweep checker for N-input gate models.
// Walks every input vector 0..2^N-1 and holds each one for SETTLE cycles.
// It then compares the gate output against the selected function.
// It counts mismatches, records the first failing vector and stops on the
// all-ones vector.
module n_input_gate_sweep_checker #(
   parameter int N      = 8,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic         stop_on_fail,
   input  logic         y_in,
   output logic [N-1:0] vec,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_cnt,
   output logic         fail_valid,
   output logic [N-1:0] fail_vec
);

   // Settle counter only has to reach SETTLE-1; keep at least one bit.
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [N-1:0]  ALL_ONES = '1;
   localparam logic [N-1:0]  VEC_ONE  = N'(1);
   localparam logic [N:0]    ERR_MAX  = {1'b1, {N{1'b0}}};
   localparam logic [N:0]    ERR_ONE  = (N+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_FIN
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    mode_q;
   logic          stop_q;
   logic          exp_y;
   logic          mismatch;

   // Expected gate output for the current vector, using the function latched at launch.
   always_comb begin
      exp_y = 1'b0;
      case (mode_q)
         2'b00:   exp_y = ~(&vec);
         2'b01:   exp_y = &vec;
         2'b10:   exp_y = ~(|vec);
         default: exp_y = |vec;
      endcase
   end

   // Case inequality so that an undriven or unknown gate output is never taken as a match.
   assign mismatch = (y_in !== exp_y);

   // Sweep sequencer. VEC only advances when leaving CHECK, so the gate sees stable inputs.
   // BUSY covers SETTLE/CHECK/FIN. DONE and PASS are issued from FIN.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= ST_IDLE;
         vec        <= '0;
         err_cnt    <= '0;
         fail_vec   <= '0;
         fail_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         cnt        <= '0;
         mode_q     <= 2'b00;
         stop_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  vec        <= '0;
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
                  cnt        <= '0;
                  mode_q     <= mode;
                  stop_q     <= stop_on_fail;
                  busy       <= 1'b1;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == CNT_LAST) begin
                  state <= ST_CHECK;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  if (err_cnt != ERR_MAX) begin
                     err_cnt <= err_cnt + ERR_ONE;
                  end
                  if (!fail_valid) begin
                     fail_vec   <= vec;
                     fail_valid <= 1'b1;
                  end
               end
               if ((vec == ALL_ONES) || (mismatch && stop_q)) begin
                  state <= ST_FIN;
               end else begin
                  vec   <= vec + VEC_ONE;
                  cnt   <= '0;
                  state <= ST_SETTLE;
               end
            end
            ST_FIN: begin
               done  <= 1'b1;
               pass  <= (err_cnt == '0);
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
